// File: rtl/turn_scheduler.sv
// rtl/turn_scheduler.sv - turn sequencing, marker advance and win detection for the card game
module turn_scheduler #(
  parameter int NUM_PLAYERS = 4,
  parameter int BOARD_LEN   = 24,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       key_valid,
  input  logic [3:0] key,
  input  logic       res_valid,
  input  logic       res_match,
  output logic       reveal,
  output logic       hide,
  output logic [3:0] sel_card,
  output logic [1:0] cur_player,
  output logic [4:0] cur_pos,
  output logic       win,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [5:0] FINISH6 = 6'(BOARD_LEN - 1);
  localparam logic [4:0] FINISH5 = 5'(BOARD_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_KEY = 3'd1,
    S_WAIT_RES = 3'd2,
    S_ADVANCE  = 3'd3,
    S_NEXT     = 3'd4,
    S_WIN      = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]    pos_q [4];
  logic [4:0]    pos_d [4];
  logic          reveal_q, reveal_d;
  logic          hide_q, hide_d;
  logic [3:0]    sel_q, sel_d;
  logic [1:0]    cp_q, cp_d;
  logic          win_q, win_d;
  logic [1:0]    winner_q, winner_d;
  logic [5:0]    cand;
  logic          occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      pos_q    <= '{default: '0};
      reveal_q <= 1'b0;
      hide_q   <= 1'b0;
      sel_q    <= '0;
      cp_q     <= '0;
      win_q    <= 1'b0;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      pos_q    <= pos_d;
      reveal_q <= reveal_d;
      hide_q   <= hide_d;
      sel_q    <= sel_d;
      cp_q     <= cp_d;
      win_q    <= win_d;
      winner_q <= winner_d;
    end
  end

  // One pass per player is enough: each pass can skip at most one occupied square.
  always_comb begin
    cand = {1'b0, pos_q[cp_q]} + 6'd1;
    occ  = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      occ = 1'b0;
      for (int j = 0; j < NUM_PLAYERS; j++) begin
        if (2'(j) != cp_q && {1'b0, pos_q[j]} == cand && cand < FINISH6) occ = 1'b1;
      end
      if (occ) cand = cand + 6'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    pos_d    = pos_q;
    reveal_d = 1'b0;
    hide_d   = 1'b0;
    sel_d    = sel_q;
    cp_d     = cp_q;
    win_d    = win_q;
    winner_d = winner_q;
    case (state_q)
      S_IDLE: begin
        pos_d = '{default: '0};
        if (start) begin
          state_d = S_WAIT_KEY;
          cp_d    = '0;
          timer_d = '0;
        end
      end
      S_WAIT_KEY: begin
        if (key_valid && key != 4'hf) begin
          sel_d    = key;
          reveal_d = 1'b1;
          state_d  = S_WAIT_RES;
        end else if (timer_q == TLAST) begin
          state_d = S_NEXT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_RES: begin
        if (res_valid) state_d = res_match ? S_ADVANCE : S_NEXT;
      end
      S_ADVANCE: begin
        if (cand >= FINISH6) begin
          pos_d[cp_q] = FINISH5;
          winner_d    = cp_q;
          win_d       = 1'b1;
          state_d     = S_WIN;
        end else begin
          pos_d[cp_q] = cand[4:0];
          timer_d     = '0;
          state_d     = S_WAIT_KEY;
        end
      end
      S_NEXT: begin
        hide_d  = 1'b1;
        cp_d    = (cp_q == 2'(NUM_PLAYERS - 1)) ? 2'd0 : cp_q + 2'd1;
        timer_d = '0;
        state_d = S_WAIT_KEY;
      end
      S_WIN: begin
        if (start) begin
          state_d  = S_IDLE;
          pos_d    = '{default: '0};
          win_d    = 1'b0;
          winner_d = '0;
          cp_d     = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign reveal     = reveal_q;
  assign hide       = hide_q;
  assign sel_card   = sel_q;
  assign cur_player = cp_q;
  assign cur_pos    = pos_q[cp_q];
  assign win        = win_q;
  assign winner     = winner_q;
  assign state      = state_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// tb/tb_turn_scheduler.sv - directed vector bench for turn_scheduler (3 players, 8 squares, timeout 10)
module tb_turn_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key = 4'h0;
  logic       res_valid = 1'b0;
  logic       res_match = 1'b0;
  logic       reveal, hide, win;
  logic [3:0] sel_card;
  logic [1:0] cur_player, winner;
  logic [4:0] cur_pos;
  logic [2:0] state;

  turn_scheduler #(.NUM_PLAYERS(3), .BOARD_LEN(8), .TIMEOUT_CYC(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_valid(key_valid), .key(key),
    .res_valid(res_valid), .res_match(res_match), .reveal(reveal), .hide(hide),
    .sel_card(sel_card), .cur_player(cur_player), .cur_pos(cur_pos), .win(win),
    .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, kv;
    logic [3:0]  k;
    logic        rv, rm;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic [18:0] act;

  assign act = {state, reveal, hide, sel_card, cur_player, cur_pos, win, winner};

  function automatic logic [18:0] pk(input int s, input int rev, input int hd, input int sel,
                                     input int cp, input int pos, input int w, input int wn);
    return {3'(s), 1'(rev), 1'(hd), 4'(sel), 2'(cp), 5'(pos), 1'(w), 2'(wn)};
  endfunction

  task automatic add(input int st, input int kv, input int k, input int rv, input int rm,
                     input logic [18:0] e);
    vec_t v;
    v.st = 1'(st); v.kv = 1'(kv); v.k = 4'(k); v.rv = 1'(rv); v.rm = 1'(rm); v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic turn_match(input int k, input int cp, input int oldp, input int newp);
    add(0, 1, k, 0, 0, pk(2, 1, 0, k, cp, oldp, 0, 0));
    add(0, 0, 0, 1, 1, pk(3, 0, 0, k, cp, oldp, 0, 0));
    add(0, 0, 0, 0, 0, pk(1, 0, 0, k, cp, newp, 0, 0));
  endtask

  task automatic turn_miss(input int k, input int cp, input int oldp, input int ncp, input int npos);
    add(0, 1, k, 0, 0, pk(2, 1, 0, k, cp, oldp, 0, 0));
    add(0, 0, 0, 1, 0, pk(4, 0, 0, k, cp, oldp, 0, 0));
    add(0, 0, 0, 0, 0, pk(1, 0, 1, k, ncp, npos, 0, 0));
  endtask

  task automatic check(input string name, input logic [18:0] a, input logic [18:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got state/rev/hide/sel/cp/pos/win/wnr=%0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d",
               name, a[18:16], a[15], a[14], a[13:10], a[9:8], a[7:3], a[2], a[1:0],
               e[18:16], e[15], e[14], e[13:10], e[9:8], e[7:3], e[2], e[1:0]);
    end
  endtask

  task automatic cyc(input int st, input int kv, input int k, input int rv, input int rm);
    start = 1'(st); key_valid = 1'(kv); key = 4'(k); res_valid = 1'(rv); res_match = 1'(rm);
    @(posedge clk);
    #1;
    start = 1'b0; key_valid = 1'b0; key = 4'h0; res_valid = 1'b0; res_match = 1'b0;
  endtask

  initial begin
    // Game 1: ignored keys, first match, build P1=4 / P2=5 via skips, P0 skips 4,5 then wins.
    add(1, 0, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 15, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 3, 0, 0, pk(2, 1, 0, 3, 0, 0, 0, 0));
    add(1, 1, 5, 0, 0, pk(2, 0, 0, 3, 0, 0, 0, 0));
    add(0, 0, 0, 1, 1, pk(3, 0, 0, 3, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, pk(1, 0, 0, 3, 0, 1, 0, 0));
    turn_match(2, 0, 1, 2);
    turn_match(4, 0, 2, 3);
    turn_miss(6, 0, 3, 1, 0);
    turn_match(1, 1, 0, 1);
    turn_match(2, 1, 1, 2);
    turn_match(7, 1, 2, 4);
    turn_miss(8, 1, 4, 2, 0);
    turn_match(9, 2, 0, 1);
    turn_match(10, 2, 1, 2);
    turn_match(11, 2, 2, 5);
    turn_miss(12, 2, 5, 0, 3);
    turn_match(13, 0, 3, 6);
    add(0, 1, 14, 0, 0, pk(2, 1, 0, 14, 0, 6, 0, 0));
    add(0, 0, 0, 1, 1, pk(3, 0, 0, 14, 0, 6, 0, 0));
    add(0, 0, 0, 0, 0, pk(5, 0, 0, 14, 0, 7, 1, 0));
    add(0, 0, 0, 0, 0, pk(5, 0, 0, 14, 0, 7, 1, 0));
    add(0, 1, 2, 0, 0, pk(5, 0, 0, 14, 0, 7, 1, 0));
    add(1, 0, 0, 0, 0, pk(0, 0, 0, 14, 0, 0, 0, 0));
    add(0, 1, 5, 0, 0, pk(0, 0, 0, 14, 0, 0, 0, 0));
    // Game 2: rotation 1,2,0,1 then P2 overshoots an occupied square 6 and wins.
    add(1, 0, 0, 0, 0, pk(1, 0, 0, 14, 0, 0, 0, 0));
    turn_miss(1, 0, 0, 1, 0);
    turn_miss(2, 1, 0, 2, 0);
    turn_miss(3, 2, 0, 0, 0);
    turn_miss(4, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) turn_match(i, 1, i, i + 1);
    turn_miss(9, 1, 6, 2, 0);
    for (int i = 0; i < 5; i++) turn_match(i + 8, 2, i, i + 1);
    add(0, 1, 10, 0, 0, pk(2, 1, 0, 10, 2, 5, 0, 0));
    add(0, 0, 0, 1, 1, pk(3, 0, 0, 10, 2, 5, 0, 0));
    add(0, 0, 0, 0, 0, pk(5, 0, 0, 10, 2, 7, 1, 2));
    add(1, 0, 0, 0, 0, pk(0, 0, 0, 10, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", act, pk(0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].st, vecs[i].kv, vecs[i].k, vecs[i].rv, vecs[i].rm);
      check($sformatf("vec%0d", i), act, vecs[i].exp);
    end

    // Reset asserted mid-game while waiting on a result with P0 at square 5.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, i, 0, 0);
      cyc(0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 0);
    end
    cyc(0, 1, 9, 0, 0);
    check("pre_reset", act, pk(2, 1, 0, 9, 0, 5, 0, 0));
    #2 rst_n = 1'b0;
    #1 check("async_reset", act, pk(0, 0, 0, 0, 0, 0, 0, 0));
    #2 rst_n = 1'b1;
    repeat (3) cyc(0, 0, 0, 0, 0);
    check("post_reset_idle", act, pk(0, 0, 0, 0, 0, 0, 0, 0));

    // Timeout: NEXT exactly 10 edges after WAIT_KEY entry.
    cyc(1, 0, 0, 0, 0);
    check("to_entry", act, pk(1, 0, 0, 0, 0, 0, 0, 0));
    repeat (9) cyc(0, 0, 0, 0, 0);
    check("to_cycle9", act, pk(1, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 0, 0);
    check("to_next", act, pk(4, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 0, 0);
    check("to_pass", act, pk(1, 0, 1, 0, 1, 0, 0, 0));
    repeat (9) cyc(0, 0, 0, 0, 0);
    check("to2_cycle9", act, pk(1, 0, 0, 0, 1, 0, 0, 0));
    cyc(0, 1, 7, 0, 0);
    check("to_key_wins", act, pk(2, 1, 0, 7, 1, 0, 0, 0));
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    check("to_after_miss", act, pk(1, 0, 1, 7, 2, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
